// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one SPI flash (mode 0, READ 0x03) between two word-read ports.
// Handshake: reqN is a level held until ackN; ackN pulses for one cycle with dataN valid that cycle.
module flash_read_arbiter #(
    parameter int CLK_DIV   = 1,
    parameter int CS_GAP    = 2,
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [ADDR_BITS-1:0] addr0,
    input  logic [ADDR_BITS-1:0] addr1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [31:0]          data0,
    output logic [31:0]          data1,
    output logic                 busy,
    output logic                 flash_csb,
    output logic                 flash_clk,
    output logic                 flash_io0,
    input  logic                 flash_io1,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, GAP = 2'd3} state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

    state_t state, state_nx;

    logic        last_grant;
    logic        grant_nx;
    logic [31:0] sreg;
    logic [31:0] rx;
    logic [15:0] div_cnt;
    logic        phase;
    logic [5:0]  bit_cnt;
    logic [15:0] gap_cnt;
    logic [31:0] data0_q;
    logic [31:0] data1_q;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [23:0] aligned_addr;
    logic [31:0] data_word;
    logic        tick;
    logic        bit_end;
    logic        sample;

    assign tick    = (div_cnt == DIV_LAST);
    assign bit_end = phase && tick;
    // Sample MISO in the first cycle SCK is high, only during the 32 data bits.
    assign sample  = phase && (div_cnt == 16'd0) && bit_cnt[5];

    assign grant_nx     = (req0 && req1) ? ~last_grant : req1;
    assign sel_addr     = grant_nx ? addr1 : addr0;
    assign aligned_addr = sel_addr[23:0] & 24'hFFFFFC;
    // Bytes arrive in address order; byte k of the word sits at bits [8k+7:8k].
    assign data_word    = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        flash_csb = 1'b1;
        flash_clk = phase;
        flash_io0 = 1'b0;
        busy      = 1'b1;
        ack0      = 1'b0;
        ack1      = 1'b0;
        data0     = data0_q;
        data1     = data1_q;
        state_dbg = state;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req0 || req1) state_nx = SHIFT;
            end
            SHIFT: begin
                flash_csb = 1'b0;
                flash_io0 = ~bit_cnt[5] & sreg[31];
                if (bit_end && bit_cnt == 6'd63) state_nx = DONE;
            end
            DONE: begin
                ack0 = ~last_grant;
                ack1 = last_grant;
                if (last_grant) data1 = data_word;
                else            data0 = data_word;
                state_nx = (GAP_LAST == 16'd0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_cnt >= GAP_LAST) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            sreg       <= '0;
            rx         <= '0;
            div_cnt    <= '0;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    phase   <= 1'b0;
                    bit_cnt <= '0;
                    if (req0 || req1) begin
                        last_grant <= grant_nx;
                        sreg       <= {8'h03, aligned_addr};
                    end
                end
                SHIFT: begin
                    div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
                    if (tick) phase <= ~phase;
                    if (sample) rx <= {rx[30:0], flash_io1};
                    // Advance to the next bit as SCK falls so MOSI only moves while SCK is low.
                    if (bit_end) begin
                        sreg    <= {sreg[30:0], 1'b0};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                DONE: begin
                    if (last_grant) data1_q <= data_word;
                    else            data0_q <= data_word;
                    gap_cnt <= 16'd1;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: two instances (CLK_DIV=1/CS_GAP=2 and CLK_DIV=4/CS_GAP=3)
// each driven against a behavioural SPI flash with a shared byte memory.
module tb_flash_read_arbiter;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    logic        req0 [N];
    logic        req1 [N];
    logic [23:0] addr0 [N];
    logic [23:0] addr1 [N];
    logic        ack0 [N];
    logic        ack1 [N];
    logic [31:0] data0 [N];
    logic [31:0] data1 [N];
    logic        busy [N];
    logic        csb [N];
    logic        sck [N];
    logic        mosi [N];
    logic [1:0]  st [N];

    logic [7:0] mem [0:511];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic mem_bit(input logic [23:0] a, input int j);
        int idx;
        idx = (int'(a) + j / 8) % 512;
        return mem[idx][7 - (j % 8)];
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int DIV  = (g == 0) ? 1 : 4;
        localparam int GAPC = (g == 0) ? 2 : 3;
        logic        miso = 1'b0;
        logic [31:0] cap = '0;
        int          bits = 0;
        int          sck_run = 0;
        int          csb_run = 0;
        logic        prev_sck = 1'b0;
        logic        prev_mosi = 1'b0;
        logic        prev_csb = 1'b1;

        flash_read_arbiter #(.CLK_DIV(DIV), .CS_GAP(GAPC), .ADDR_BITS(24)) dut (
            .clk(clk), .rst(rst),
            .req0(req0[g]), .req1(req1[g]), .addr0(addr0[g]), .addr1(addr1[g]),
            .ack0(ack0[g]), .ack1(ack1[g]), .data0(data0[g]), .data1(data1[g]),
            .busy(busy[g]), .flash_csb(csb[g]), .flash_clk(sck[g]),
            .flash_io0(mosi[g]), .flash_io1(miso), .state_dbg(st[g])
        );

        // Flash model plus per-cycle protocol checks, evaluated mid-cycle.
        always @(negedge clk) begin
            if (csb[g]) begin
                bits = 0;
            end else if (sck[g] && !prev_sck) begin
                if (bits < 32) cap = {cap[30:0], mosi[g]};
                else           miso = mem_bit(cap[23:0], bits - 32);
                bits++;
            end
            if (!csb[g]) chk("csb_only_in_shift", 32'(st[g]), 32'd1);
            if (ack0[g] || ack1[g]) chk("ack_exclusive", 32'(ack0[g] & ack1[g]), 32'd0);
            if (sck[g] && prev_sck) chk("mosi_stable_high", 32'(mosi[g]), 32'(prev_mosi));
            if (sck[g] != prev_sck && !prev_csb) begin
                chk("sck_half_period", 32'(sck_run), 32'(DIV));
                sck_run = 1;
            end else if (!csb[g]) begin
                sck_run++;
            end else begin
                sck_run = 0;
            end
            if (!csb[g] && prev_csb) chk("cs_gap_min", 32'(csb_run >= GAPC), 32'd1);
            csb_run   = csb[g] ? csb_run + 1 : 0;
            prev_sck  = sck[g];
            prev_mosi = mosi[g];
            prev_csb  = csb[g];
        end
    end

    task automatic wait_any(input int g, input int limit, output int n, output int port);
        n = 0;
        port = -1;
        while (port < 0 && n < limit) begin
            @(negedge clk);
            n++;
            if (ack0[g]) port = 0;
            else if (ack1[g]) port = 1;
        end
        chk("ack_seen", 32'(port >= 0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p;
        int acks;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0]     = 8'hA0; mem[1]     = 8'hA1; mem[2]     = 8'hA2; mem[3]     = 8'hA3;
        mem[4]     = 8'hB0; mem[5]     = 8'hB1; mem[6]     = 8'hB2; mem[7]     = 8'hB3;
        mem[9'h100] = 8'h11; mem[9'h101] = 8'h22; mem[9'h102] = 8'h33; mem[9'h103] = 8'h44;

        rst = 1'b1;
        for (int g = 0; g < N; g++) begin
            req0[g] = 1'b0; req1[g] = 1'b0; addr0[g] = '0; addr1[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk("rst_csb", 32'(csb[g]), 32'd1);
            chk("rst_sck", 32'(sck[g]), 32'd0);
            chk("rst_mosi", 32'(mosi[g]), 32'd0);
            chk("rst_acks", 32'({ack0[g], ack1[g]}), 32'd0);
            chk("rst_data0", data0[g], 32'd0);
            chk("rst_data1", data1[g], 32'd0);
            chk("rst_busy", 32'(busy[g]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single port-0 read of 0x100.
        addr0[0] = 24'h000100; req0[0] = 1'b1;
        wait_any(0, 200, n, p);
        req0[0] = 1'b0;
        chk("t1_ack_cycle", 32'(n), 32'd129);
        chk("t1_port", 32'(p), 32'd0);
        chk("t1_data0", data0[0], 32'h44332211);
        chk("t1_mosi_stream", g_dut[0].cap, 32'h03000100);
        @(negedge clk);
        chk("t1_busy_gap", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("t1_busy_low", 32'(busy[0]), 32'd0);
        chk("t1_data0_held", data0[0], 32'h44332211);

        // Reset in the middle of a port-0 read.
        addr0[0] = 24'h000100; req0[0] = 1'b1;
        repeat (80) @(negedge clk);
        chk("rst_mid_sck_high", 32'(sck[0]), 32'd1);
        rst = 1'b1; req0[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_csb", 32'(csb[0]), 32'd1);
        chk("rst_mid_sck", 32'(sck[0]), 32'd0);
        chk("rst_mid_data0", data0[0], 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        rst = 1'b0;
        acks = 0;
        repeat (150) begin
            @(negedge clk);
            if (ack0[0] || ack1[0]) acks++;
        end
        chk("rst_mid_no_ack", 32'(acks), 32'd0);

        // Simultaneous requests after reset: port 0 first, then port 1.
        addr0[0] = 24'h000000; addr1[0] = 24'h000004;
        req0[0] = 1'b1; req1[0] = 1'b1;
        wait_any(0, 200, n, p);
        req0[0] = 1'b0;
        chk("t2_first_cycle", 32'(n), 32'd129);
        chk("t2_first_port", 32'(p), 32'd0);
        chk("t2_data0", data0[0], 32'hA3A2A1A0);
        chk("t2_addr0_sent", g_dut[0].cap, 32'h03000000);
        wait_any(0, 200, n, p);
        chk("t2_second_gap", 32'(n), 32'd131);
        chk("t2_second_port", 32'(p), 32'd1);
        chk("t2_data1", data1[0], 32'hB3B2B1B0);
        chk("t2_addr1_sent", g_dut[0].cap, 32'h03000004);

        // Both held high: grants alternate 0,1,0,1.
        req0[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_any(0, 200, n, p);
            chk("rr_interval", 32'(n), 32'd131);
            chk("rr_port", 32'(p), 32'(i % 2));
            if (i % 2 == 0) chk("rr_data0", data0[0], 32'hA3A2A1A0);
            else            chk("rr_data1", data1[0], 32'hB3B2B1B0);
        end
        req0[0] = 1'b0; req1[0] = 1'b0;

        // Unaligned port-1 address is transmitted word aligned.
        addr1[0] = 24'h000103; req1[0] = 1'b1;
        wait_any(0, 200, n, p);
        req1[0] = 1'b0;
        chk("t3_port", 32'(p), 32'd1);
        chk("t3_addr_aligned", g_dut[0].cap, 32'h03000100);
        chk("t3_data1", data1[0], 32'h44332211);
        chk("t3_data0_held", data0[0], 32'hA3A2A1A0);

        // Slow instance: CLK_DIV=4, CS_GAP=3, back-to-back port-0 reads.
        repeat (5) @(negedge clk);
        addr0[1] = 24'h000100; req0[1] = 1'b1;
        wait_any(1, 600, n, p);
        chk("t4_ack_cycle", 32'(n), 32'd513);
        chk("t4_port", 32'(p), 32'd0);
        chk("t4_data0", data0[1], 32'h44332211);
        wait_any(1, 600, n, p);
        req0[1] = 1'b0;
        chk("t4_second_interval", 32'(n), 32'd516);
        chk("t4_second_data0", data0[1], 32'h44332211);
        repeat (5) @(negedge clk);
        chk("t4_idle", 32'(busy[1]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flash_read_arbiter.md
# flash_read_arbiter

Shares the single off-chip SPI flash (user_flash pins on mprj_io[11:8]) between two Microwatt read requesters: port 0, instruction fetch/boot, and port 1, data load. Each granted request becomes one standard-SPI READ (0x03) transaction that returns one 32-bit word. Requests are arbitrated round-robin. The block sits between the core's fetch/load paths and the flash pads.

## Interface
- CLK_DIV, 1: SCK half-period in clk cycles (≥1)
- CS_GAP, 2: minimum clk cycles flash_csb stays high between transactions (≥1)
- ADDR_BITS, 24: flash byte-address width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  read request; level, held until matching ack
- addr0 / addr1  in  ADDR_BITS  byte address; must be stable while req high
- ack0 / ack1  out  1  one-cycle pulse: read data valid
- data0 / data1  out  32  read word; valid in the ack cycle, held until the next ack on the same port
- busy  out  1  transaction or CS gap in progress
- flash_csb  out  1  chip select, active low
- flash_clk  out  1  SCK, SPI mode 0
- flash_io0  out  1  MOSI
- flash_io1  in  1  MISO

## Operation
- Reset values:
  - flash_csb=1, flash_clk=0, flash_io0=0
  - ack0=ack1=0, data0=data1=0, busy=0
  - last_grant=1, so port 0 wins the first tie.
- States: IDLE → SHIFT → DONE → GAP → IDLE.
- IDLE:
  - If any req is high, grant the requester not equal to last_grant when both are high, otherwise the single requester.
  - On grant: latch {0x03, addr[23:2], 2'b00} into a 32-bit shift register, set last_grant, go to SHIFT.
  - Address bits [1:0] are forced to zero (word aligned).
- SHIFT:
  - flash_csb=0. Bits are sent MSB first: 8 command bits, then 24 address bits, then 32 data bits are read (64 bit periods in total).
  - flash_io0 changes only while flash_clk is low.
  - flash_io1 is sampled in the cycle flash_clk rises.
  - During data bits flash_io0=0.
  - Data byte k (k=0..3, flash byte at addr+k) lands in data[8k+7:8k], i.e. little-endian.
- DONE (1 cycle):
  - flash_csb=1, flash_clk=0.
  - Pulse ack of the granted port and update its data register.
  - Go to GAP.
- GAP: hold flash_csb=1 for CS_GAP cycles, counting from the DONE cycle inclusive, then go to IDLE.
- A requester's req may drop in the cycle after its ack. A req still high in IDLE is a new request.
- A req deasserted mid-transaction is not supported. The transaction completes and ack is still issued.
- busy=1 in SHIFT, DONE and GAP.
- Reset mid-transaction: next cycle all outputs take reset values, no ack is issued, and the partial word is discarded.

## Timing
- Cycle 0: IDLE samples req.
- Cycle 1: flash_csb falls and flash_io0 = command bit 7.
- Bit n (0..63) occupies cycles 1+2n·CLK_DIV … 1+(2n+2)·CLK_DIV−1.
  - flash_clk is high for the second half of each bit.
  - Rising edge of bit n at cycle 1+(2n+1)·CLK_DIV.
- DONE / ack at cycle 1+128·CLK_DIV: 129 for CLK_DIV=1, 513 for CLK_DIV=4.
- Earliest next grant: DONE cycle + CS_GAP.
  - Back-to-back grants with CLK_DIV=1, CS_GAP=2 are 131 cycles apart.
- Simultaneous req0/req1 in IDLE: exactly one is granted per transaction, round-robin.
- A continuously requesting port can never starve the other.

## Test plan
- Flash bytes 0x100..0x103 = 11 22 33 44; req0 addr0=0x000100 → MOSI stream 0x03,0x00,0x01,0x00; ack0 at cycle 129; data0=0x44332211; busy low from cycle 131.
- req0 and req1 both high after reset (addr0=0x0, addr1=0x4) → port 0 served first. Port 1 is granted in the first IDLE after ack0, and ack1 arrives 131 cycles after ack0. Repeat with both held high → grants alternate 0,1,0,1.
- addr1=0x000103 → transmitted address 0x000100; data1 equals the word at 0x100.
- CLK_DIV=4, CS_GAP=3 → flash_clk high/low phases of 4 cycles; ack at cycle 513; flash_csb high for ≥3 cycles before the next fall.
- rst pulsed at cycle 80 of a port-0 read → flash_csb=1 and flash_clk=0 at cycle 81; no ack0; data0=0. A fresh request after reset completes normally with correct data.
- Check on every flash_clk edge → flash_io0 never toggles while flash_clk is high; flash_csb is never low outside SHIFT; ack0 and ack1 are never high in the same cycle.
